// File: rtl/kmx_mac_bus_if.sv
// KMX peripheral-bus slave for the EMAC register window and its DMA channels.
// The address decoder turns the register window into one-hot read and write strobes.
// Each DMA channel has a small request/hold engine that moves BURST_LEN words per burst.
//
// DMA channel states:
//   state  | meaning
//   S_IDLE | no service wanted, req/hold low
//   S_REQ  | requesting the bus, waiting for grant
//   S_XFER | bus held, counting direction strobes
//   S_DONE | one-cycle burst-complete pulse
module kmx_mac_bus_if #(
  parameter int             PAW        = 11,
  parameter int             DATA_WIDTH = 32,
  parameter int             BASE_ADDR  = 'h80,
  parameter int             NREG       = 8,
  parameter int             NCH        = 2,
  parameter logic [NCH-1:0] CH_DIR     = NCH'(2'b01),
  parameter int             BURST_LEN  = 4
) (
  input  logic                  sysclk_i,
  input  logic                  reset_i,
  input  logic [PAW-1:0]        periph_adr_i,
  input  logic [DATA_WIDTH-1:0] src_i,
  input  logic                  sedrd_i,
  input  logic                  edwr_h_i,
  input  logic                  edwr_l_i,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [NREG-1:0]       reg_wrh_o,
  output logic [NREG-1:0]       reg_wrl_o,
  output logic [NREG-1:0]       reg_rd_o,
  input  logic [NCH-1:0]        grant_dma_i,
  input  logic                  dma_req_wr_i,
  input  logic                  dma_req_rd_i,
  output logic [NCH-1:0]        req_dma_o,
  output logic [NCH-1:0]        hold_dma_o,
  input  logic [NCH-1:0]        ch_need_i,
  output logic [NCH-1:0]        ch_strobe_o,
  output logic [NCH-1:0]        ch_done_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} dma_state_t;

  localparam int            CW        = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);

  logic [NREG-1:0] reg_sel;
  dma_state_t      st  [NCH];
  logic [CW-1:0]   cnt [NCH];
  logic [NCH-1:0]  in_xfer;
  logic [NCH-1:0]  dir_stb;
  logic [NCH-1:0]  wins;
  logic            granted_below;
  logic            any_xfer;

  // One-hot register select; all zero outside the window.
  always_comb begin
    reg_sel = '0;
    for (int r = 0; r < NREG; r++)
      reg_sel[r] = ({1'b0, periph_adr_i} == (PAW+1)'(BASE_ADDR + r));
  end

  assign reg_rd_o = sedrd_i ? '0 : reg_sel;

  // Write strobes are delayed one cycle so they line up with the captured data.
  always_ff @(posedge sysclk_i or negedge reset_i) begin
    if (!reset_i) begin
      reg_wrh_o <= '0;
      reg_wrl_o <= '0;
      wr_data_o <= '0;
    end else begin
      reg_wrh_o <= edwr_h_i ? '0 : reg_sel;
      reg_wrl_o <= edwr_l_i ? '0 : reg_sel;
      if (!edwr_h_i || !edwr_l_i)
        wr_data_o <= src_i;
    end
  end

  // Per-channel word strobe selection and lowest-index grant priority.
  always_comb begin
    in_xfer       = '0;
    dir_stb       = '0;
    wins          = '0;
    granted_below = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      in_xfer[i]    = (st[i] == S_XFER);
      dir_stb[i]    = CH_DIR[i] ? dma_req_wr_i : dma_req_rd_i;
      wins[i]       = grant_dma_i[i] && !granted_below;
      granted_below = granted_below | grant_dma_i[i];
    end
  end

  // A channel may only claim the bus once nobody else holds it.
  assign any_xfer    = |in_xfer;
  assign ch_strobe_o = in_xfer & dir_stb;

  // DMA channel engines with registered req/hold/done outputs.
  always_ff @(posedge sysclk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NCH; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= '0;
      end
      req_dma_o  <= '0;
      hold_dma_o <= '0;
      ch_done_o  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        case (st[i])
          S_IDLE: begin
            if (ch_need_i[i]) begin
              st[i]        <= S_REQ;
              req_dma_o[i] <= 1'b1;
            end
          end
          S_REQ: begin
            if (!ch_need_i[i]) begin
              st[i]        <= S_IDLE;
              req_dma_o[i] <= 1'b0;
            end else if (wins[i] && !any_xfer) begin
              st[i]         <= S_XFER;
              hold_dma_o[i] <= 1'b1;
            end
          end
          S_XFER: begin
            // A terminal word wins over a simultaneous grant drop.
            if (dir_stb[i] && cnt[i] == LAST_WORD) begin
              st[i]         <= S_DONE;
              cnt[i]        <= '0;
              req_dma_o[i]  <= 1'b0;
              hold_dma_o[i] <= 1'b0;
              ch_done_o[i]  <= 1'b1;
            end else begin
              if (dir_stb[i])
                cnt[i] <= cnt[i] + 1'b1;
              if (!grant_dma_i[i]) begin
                st[i]         <= S_REQ;
                hold_dma_o[i] <= 1'b0;
              end
            end
          end
          S_DONE: begin
            ch_done_o[i] <= 1'b0;
            if (ch_need_i[i]) begin
              st[i]        <= S_REQ;
              req_dma_o[i] <= 1'b1;
            end else begin
              st[i] <= S_IDLE;
            end
          end
          default: begin
            st[i]         <= S_IDLE;
            req_dma_o[i]  <= 1'b0;
            hold_dma_o[i] <= 1'b0;
            ch_done_o[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kmx_mac_bus_if.sv
// Testbench for kmx_mac_bus_if: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the decoder and DMA channels.
module tb_kmx_mac_bus_if;

  localparam int         BASE  = 'h80;
  localparam int         NREG  = 8;
  localparam int         BURST = 4;
  localparam logic [1:0] DIR   = 2'b01;

  logic        sysclk_i = 1'b0;
  logic        reset_i;
  logic [10:0] periph_adr_i;
  logic [31:0] src_i;
  logic        sedrd_i, edwr_h_i, edwr_l_i;
  logic [31:0] wr_data_o;
  logic [7:0]  reg_wrh_o, reg_wrl_o, reg_rd_o;
  logic [1:0]  grant_dma_i;
  logic        dma_req_wr_i, dma_req_rd_i;
  logic [1:0]  req_dma_o, hold_dma_o, ch_need_i, ch_strobe_o, ch_done_o;

  always #5 sysclk_i = ~sysclk_i;

  kmx_mac_bus_if #(
    .PAW(11), .DATA_WIDTH(32), .BASE_ADDR(BASE), .NREG(NREG),
    .NCH(2), .CH_DIR(DIR), .BURST_LEN(BURST)
  ) dut (
    .sysclk_i(sysclk_i), .reset_i(reset_i), .periph_adr_i(periph_adr_i),
    .src_i(src_i), .sedrd_i(sedrd_i), .edwr_h_i(edwr_h_i), .edwr_l_i(edwr_l_i),
    .wr_data_o(wr_data_o), .reg_wrh_o(reg_wrh_o), .reg_wrl_o(reg_wrl_o),
    .reg_rd_o(reg_rd_o), .grant_dma_i(grant_dma_i), .dma_req_wr_i(dma_req_wr_i),
    .dma_req_rd_i(dma_req_rd_i), .req_dma_o(req_dma_o), .hold_dma_o(hold_dma_o),
    .ch_need_i(ch_need_i), .ch_strobe_o(ch_strobe_o), .ch_done_o(ch_done_o)
  );

  typedef struct packed {
    logic [1:0] need;
    logic [1:0] grant;
    logic       wr;
    logic       rd;
  } stim_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus, who is requesting, words moved per channel.
  int          owner;
  bit   [1:0]  pend;
  int          words [2];
  logic [7:0]  m_wrh, m_wrl, m_rd;
  logic [31:0] m_wd;
  logic [1:0]  m_req, m_hold, m_done, m_stb;

  function automatic logic [7:0] onehot_of(input logic [10:0] a);
    int off;
    off = int'(a) - BASE;
    if (off >= 0 && off < NREG) return 8'(1 << off);
    return 8'h00;
  endfunction

  function automatic bit ch_word(input int ch);
    return DIR[ch] ? dma_req_wr_i : dma_req_rd_i;
  endfunction

  function automatic int lowest_grant();
    if (grant_dma_i[0]) return 0;
    if (grant_dma_i[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; pend = 2'b00; words[0] = 0; words[1] = 0;
    m_wrh = '0; m_wrl = '0; m_rd = '0; m_wd = '0;
    m_req = '0; m_hold = '0; m_done = '0; m_stb = '0;
  endtask

  task automatic model_comb();
    m_rd  = sedrd_i ? 8'h00 : onehot_of(periph_adr_i);
    m_stb = 2'b00;
    if (owner >= 0 && ch_word(owner)) m_stb[owner] = 1'b1;
  endtask

  task automatic model_clock();
    logic [7:0] oh;
    logic [1:0] nd;
    int o0;
    oh    = onehot_of(periph_adr_i);
    m_wrh = edwr_h_i ? 8'h00 : oh;
    m_wrl = edwr_l_i ? 8'h00 : oh;
    if (!edwr_h_i || !edwr_l_i) m_wd = src_i;
    o0 = owner;
    nd = 2'b00;
    if (o0 >= 0) begin
      if (ch_word(o0)) words[o0]++;
      if (ch_word(o0) && words[o0] == BURST) begin
        words[o0] = 0; owner = -1; nd[o0] = 1'b1;
      end else if (!grant_dma_i[o0]) begin
        owner = -1; pend[o0] = 1'b1;
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (ch != o0) begin
        if (!pend[ch]) pend[ch] = ch_need_i[ch];
        else if (!ch_need_i[ch]) pend[ch] = 1'b0;
        else if (o0 < 0 && lowest_grant() == ch) begin
          owner = ch; pend[ch] = 1'b0;
        end
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      m_req[ch]  = pend[ch] || (owner == ch);
      m_hold[ch] = (owner == ch);
    end
    m_done = nd;
  endtask

  task automatic tick();
    @(posedge sysclk_i);
    model_clock();
    #1;
  endtask

  task automatic set_idle();
    periph_adr_i = '0; src_i = '0; sedrd_i = 1'b1; edwr_h_i = 1'b1; edwr_l_i = 1'b1;
    grant_dma_i = '0; dma_req_wr_i = 1'b0; dma_req_rd_i = 1'b0; ch_need_i = '0;
  endtask

  task automatic test_reset();
    set_idle();
    reset_i = 1'b0;
    src_i = 32'h1234_5678; edwr_l_i = 1'b0; periph_adr_i = 11'(BASE);
    ch_need_i = 2'b11; grant_dma_i = 2'b11; dma_req_wr_i = 1'b1;
    model_reset();
    repeat (2) @(posedge sysclk_i);
    #1;
    n_checks++;
    if ({wr_data_o, reg_wrh_o, reg_wrl_o, reg_rd_o, req_dma_o, hold_dma_o, ch_strobe_o, ch_done_o} !== '0)
      $display("FAIL reset_outputs: got %h wr=%h req=%b hold=%b want all 0", wr_data_o, reg_wrl_o, req_dma_o, hold_dma_o);
    else n_pass++;
    set_idle();
    reset_i = 1'b1;
    tick();
    n_checks++;
    if ({wr_data_o, reg_wrh_o, reg_wrl_o, req_dma_o, hold_dma_o, ch_done_o} !== {m_wd, m_wrh, m_wrl, m_req, m_hold, m_done})
      $display("FAIL reset_idle_cycle: got req=%b hold=%b wrl=%h want req=%b hold=%b wrl=%h", req_dma_o, hold_dma_o, reg_wrl_o, m_req, m_hold, m_wrl);
    else n_pass++;
  endtask

  task automatic test_write_decode();
    set_idle();
    periph_adr_i = 11'(BASE + 3); edwr_l_i = 1'b0; src_i = 32'hDEAD_BEEF;
    tick();
    set_idle();
    n_checks++;
    if ({reg_wrl_o, reg_wrh_o, wr_data_o} !== {8'h08, 8'h00, 32'hDEAD_BEEF})
      $display("FAIL write_low_base3: got wrl=%h wrh=%h data=%h want 08 00 deadbeef", reg_wrl_o, reg_wrh_o, wr_data_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({reg_wrl_o, wr_data_o} !== {8'h00, 32'hDEAD_BEEF})
      $display("FAIL write_pulse_hold: got wrl=%h data=%h want 00 deadbeef", reg_wrl_o, wr_data_o);
    else n_pass++;
    periph_adr_i = 11'(BASE + 5); edwr_l_i = 1'b0; edwr_h_i = 1'b0; src_i = 32'h0BAD_F00D;
    tick();
    set_idle();
    n_checks++;
    if ({reg_wrh_o, reg_wrl_o} !== {8'h20, 8'h20})
      $display("FAIL write_both_halves: got wrh=%h wrl=%h want 20 20", reg_wrh_o, reg_wrl_o);
    else n_pass++;
    for (int k = 0; k < 40; k++) begin
      periph_adr_i = 11'(BASE - 2 + int'($urandom_range(0, 11)));
      sedrd_i  = 1'($urandom_range(0, 1));
      edwr_h_i = 1'($urandom_range(0, 1));
      edwr_l_i = 1'($urandom_range(0, 1));
      src_i    = $urandom();
      #1;
      model_comb();
      n_checks++;
      if (reg_rd_o !== m_rd)
        $display("FAIL rand_reg_rd: adr=%h got %h want %h", periph_adr_i, reg_rd_o, m_rd);
      else n_pass++;
      tick();
      n_checks++;
      if ({wr_data_o, reg_wrh_o, reg_wrl_o} !== {m_wd, m_wrh, m_wrl})
        $display("FAIL rand_reg_wr: got %h %h %h want %h %h %h", wr_data_o, reg_wrh_o, reg_wrl_o, m_wd, m_wrh, m_wrl);
      else n_pass++;
    end
    set_idle();
  endtask

  task automatic test_read_decode();
    set_idle();
    sedrd_i = 1'b0; periph_adr_i = 11'(BASE + 7);
    #1;
    n_checks++;
    if (reg_rd_o !== 8'h80) $display("FAIL read_base7: got %h want 80", reg_rd_o);
    else n_pass++;
    periph_adr_i = 11'(BASE + 8); edwr_l_i = 1'b0; src_i = 32'hCAFE_0001;
    #1;
    n_checks++;
    if (reg_rd_o !== 8'h00) $display("FAIL read_base8_miss: got %h want 00", reg_rd_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({reg_wrl_o, wr_data_o} !== {8'h00, 32'hCAFE_0001})
      $display("FAIL write_miss_data: got wrl=%h data=%h want 00 cafe0001", reg_wrl_o, wr_data_o);
    else n_pass++;
    edwr_l_i = 1'b1; periph_adr_i = 11'(BASE - 1);
    #1;
    n_checks++;
    if (reg_rd_o !== 8'h00) $display("FAIL read_base_m1_miss: got %h want 00", reg_rd_o);
    else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_dma_burst();
    stim_t seq[$];
    int p0 = 0, dones = 0, done_at = -1;
    seq.push_back({2'b01, 2'b00, 1'b0, 1'b0});
    seq.push_back({2'b01, 2'b01, 1'b0, 1'b0});
    repeat (3) seq.push_back({2'b01, 2'b01, 1'b1, 1'b0});
    seq.push_back({2'b00, 2'b01, 1'b1, 1'b0});
    repeat (2) seq.push_back({2'b00, 2'b00, 1'b0, 1'b0});
    set_idle();
    for (int k = 0; k < seq.size(); k++) begin
      ch_need_i = seq[k].need; grant_dma_i = seq[k].grant;
      dma_req_wr_i = seq[k].wr; dma_req_rd_i = seq[k].rd;
      #1;
      model_comb();
      n_checks++;
      if (ch_strobe_o !== m_stb) $display("FAIL burst_strobe[%0d]: got %b want %b", k, ch_strobe_o, m_stb);
      else n_pass++;
      if (ch_strobe_o[0]) p0++;
      tick();
      n_checks++;
      if ({req_dma_o, hold_dma_o, ch_done_o} !== {m_req, m_hold, m_done})
        $display("FAIL burst_ctl[%0d]: got req=%b hold=%b done=%b want %b %b %b", k, req_dma_o, hold_dma_o, ch_done_o, m_req, m_hold, m_done);
      else n_pass++;
      if (ch_done_o[0]) begin dones++; if (done_at < 0) done_at = k; end
    end
    n_checks++;
    if ({p0, dones, done_at} !== {32'd4, 32'd1, 32'd5})
      $display("FAIL burst_summary: got strobes=%0d dones=%0d done_at=%0d want 4 1 5", p0, dones, done_at);
    else n_pass++;
    n_checks++;
    if ({req_dma_o, hold_dma_o} !== 4'b0000) $display("FAIL burst_end_idle: got req=%b hold=%b want 00 00", req_dma_o, hold_dma_o);
    else n_pass++;
    set_idle();
  endtask

  task automatic test_grant_drop();
    stim_t seq[$];
    int p0 = 0, done_at = -1;
    seq.push_back({2'b01, 2'b00, 1'b0, 1'b0});
    seq.push_back({2'b01, 2'b01, 1'b0, 1'b0});
    repeat (2) seq.push_back({2'b01, 2'b01, 1'b1, 1'b0});
    seq.push_back({2'b01, 2'b00, 1'b0, 1'b0});
    seq.push_back({2'b01, 2'b01, 1'b0, 1'b0});
    seq.push_back({2'b01, 2'b01, 1'b1, 1'b0});
    seq.push_back({2'b00, 2'b01, 1'b1, 1'b0});
    repeat (2) seq.push_back({2'b00, 2'b00, 1'b0, 1'b0});
    set_idle();
    for (int k = 0; k < seq.size(); k++) begin
      ch_need_i = seq[k].need; grant_dma_i = seq[k].grant;
      dma_req_wr_i = seq[k].wr; dma_req_rd_i = seq[k].rd;
      #1;
      model_comb();
      n_checks++;
      if (ch_strobe_o !== m_stb) $display("FAIL drop_strobe[%0d]: got %b want %b", k, ch_strobe_o, m_stb);
      else n_pass++;
      if (ch_strobe_o[0]) p0++;
      tick();
      n_checks++;
      if ({req_dma_o, hold_dma_o, ch_done_o} !== {m_req, m_hold, m_done})
        $display("FAIL drop_ctl[%0d]: got req=%b hold=%b done=%b want %b %b %b", k, req_dma_o, hold_dma_o, ch_done_o, m_req, m_hold, m_done);
      else n_pass++;
      if (k == 4) begin
        n_checks++;
        if ({req_dma_o[0], hold_dma_o[0]} !== 2'b10)
          $display("FAIL drop_back_to_req: got req=%b hold=%b want 1 0", req_dma_o[0], hold_dma_o[0]);
        else n_pass++;
      end
      if (ch_done_o[0] && done_at < 0) done_at = k;
    end
    n_checks++;
    if ({p0, done_at} !== {32'd4, 32'd7})
      $display("FAIL drop_resume: got strobes=%0d done_at=%0d want 4 7", p0, done_at);
    else n_pass++;
    set_idle();
  endtask

  task automatic test_arbitration();
    stim_t seq[$];
    int p0 = 0, p1 = 0, d0 = -1, d1 = -1;
    bit both_held = 1'b0;
    seq.push_back({2'b11, 2'b00, 1'b0, 1'b0});
    seq.push_back({2'b11, 2'b11, 1'b0, 1'b0});
    seq.push_back({2'b11, 2'b11, 1'b0, 1'b1});
    repeat (3) seq.push_back({2'b11, 2'b11, 1'b1, 1'b0});
    seq.push_back({2'b10, 2'b11, 1'b1, 1'b0});
    seq.push_back({2'b10, 2'b10, 1'b0, 1'b0});
    repeat (3) seq.push_back({2'b10, 2'b10, 1'b0, 1'b1});
    seq.push_back({2'b00, 2'b10, 1'b0, 1'b1});
    seq.push_back({2'b00, 2'b00, 1'b0, 1'b0});
    set_idle();
    for (int k = 0; k < seq.size(); k++) begin
      ch_need_i = seq[k].need; grant_dma_i = seq[k].grant;
      dma_req_wr_i = seq[k].wr; dma_req_rd_i = seq[k].rd;
      #1;
      model_comb();
      n_checks++;
      if (ch_strobe_o !== m_stb) $display("FAIL arb_strobe[%0d]: got %b want %b", k, ch_strobe_o, m_stb);
      else n_pass++;
      if (ch_strobe_o[0]) p0++;
      if (ch_strobe_o[1]) p1++;
      tick();
      n_checks++;
      if ({req_dma_o, hold_dma_o, ch_done_o} !== {m_req, m_hold, m_done})
        $display("FAIL arb_ctl[%0d]: got req=%b hold=%b done=%b want %b %b %b", k, req_dma_o, hold_dma_o, ch_done_o, m_req, m_hold, m_done);
      else n_pass++;
      if (k == 1) begin
        n_checks++;
        if ({req_dma_o, hold_dma_o} !== 4'b1101)
          $display("FAIL arb_lowest_wins: got req=%b hold=%b want 11 01", req_dma_o, hold_dma_o);
        else n_pass++;
      end
      if (hold_dma_o === 2'b11) both_held = 1'b1;
      if (ch_done_o[0] && d0 < 0) d0 = k;
      if (ch_done_o[1] && d1 < 0) d1 = k;
    end
    n_checks++;
    if ({p0, p1, d0, d1, 31'd0, both_held} !== {32'd4, 32'd4, 32'd6, 32'd11, 32'd0})
      $display("FAIL arb_summary: got p0=%0d p1=%0d d0=%0d d1=%0d both=%0d want 4 4 6 11 0", p0, p1, d0, d1, both_held);
    else n_pass++;
    set_idle();
  endtask

  task automatic test_reset_mid_burst();
    stim_t seq[$];
    int p0 = 0, done_at = -1;
    set_idle();
    ch_need_i = 2'b01; tick();
    grant_dma_i = 2'b01; tick();
    dma_req_wr_i = 1'b1; tick();
    periph_adr_i = 11'(BASE + 1); edwr_l_i = 1'b0; src_i = 32'h5555_AAAA;
    tick();
    n_checks++;
    if ({req_dma_o[0], hold_dma_o[0], reg_wrl_o} !== {2'b11, 8'h02})
      $display("FAIL pre_reset_state: got req=%b hold=%b wrl=%h want 1 1 02", req_dma_o[0], hold_dma_o[0], reg_wrl_o);
    else n_pass++;
    reset_i = 1'b0;
    #1;
    n_checks++;
    if ({req_dma_o, hold_dma_o, ch_done_o, reg_wrh_o, reg_wrl_o, wr_data_o} !== '0)
      $display("FAIL reset_async_drop: got req=%b hold=%b wrl=%h data=%h want all 0", req_dma_o, hold_dma_o, reg_wrl_o, wr_data_o);
    else n_pass++;
    model_reset();
    set_idle();
    @(posedge sysclk_i);
    #1;
    reset_i = 1'b1;
    seq.push_back({2'b01, 2'b00, 1'b0, 1'b0});
    seq.push_back({2'b01, 2'b01, 1'b0, 1'b0});
    repeat (3) seq.push_back({2'b01, 2'b01, 1'b1, 1'b0});
    seq.push_back({2'b00, 2'b01, 1'b1, 1'b0});
    seq.push_back({2'b00, 2'b00, 1'b0, 1'b0});
    for (int k = 0; k < seq.size(); k++) begin
      ch_need_i = seq[k].need; grant_dma_i = seq[k].grant;
      dma_req_wr_i = seq[k].wr; dma_req_rd_i = seq[k].rd;
      #1;
      model_comb();
      n_checks++;
      if (ch_strobe_o !== m_stb) $display("FAIL post_reset_strobe[%0d]: got %b want %b", k, ch_strobe_o, m_stb);
      else n_pass++;
      if (ch_strobe_o[0]) p0++;
      tick();
      n_checks++;
      if ({req_dma_o, hold_dma_o, ch_done_o} !== {m_req, m_hold, m_done})
        $display("FAIL post_reset_ctl[%0d]: got req=%b hold=%b done=%b want %b %b %b", k, req_dma_o, hold_dma_o, ch_done_o, m_req, m_hold, m_done);
      else n_pass++;
      if (ch_done_o[0] && done_at < 0) done_at = k;
    end
    n_checks++;
    if ({p0, done_at} !== {32'd4, 32'd5})
      $display("FAIL post_reset_full_burst: got strobes=%0d done_at=%0d want 4 5", p0, done_at);
    else n_pass++;
    set_idle();
  endtask

  task automatic test_random_traffic();
    set_idle();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) ch_need_i[0] = ~ch_need_i[0];
      if ($urandom_range(0, 7) == 0) ch_need_i[1] = ~ch_need_i[1];
      if ($urandom_range(0, 3) == 0) grant_dma_i = 2'($urandom_range(0, 3));
      dma_req_wr_i = 1'($urandom_range(0, 1));
      dma_req_rd_i = 1'($urandom_range(0, 1));
      periph_adr_i = 11'(BASE - 2 + int'($urandom_range(0, 11)));
      sedrd_i  = 1'($urandom_range(0, 1));
      edwr_h_i = ($urandom_range(0, 3) != 0);
      edwr_l_i = ($urandom_range(0, 3) != 0);
      src_i    = $urandom();
      #1;
      model_comb();
      n_checks++;
      if ({reg_rd_o, ch_strobe_o} !== {m_rd, m_stb})
        $display("FAIL rand_comb[%0d]: got rd=%h stb=%b want %h %b", k, reg_rd_o, ch_strobe_o, m_rd, m_stb);
      else n_pass++;
      tick();
      n_checks++;
      if ({wr_data_o, reg_wrh_o, reg_wrl_o, req_dma_o, hold_dma_o, ch_done_o} !== {m_wd, m_wrh, m_wrl, m_req, m_hold, m_done})
        $display("FAIL rand_regs[%0d]: got req=%b hold=%b done=%b wrh=%h wrl=%h want %b %b %b %h %h",
                 k, req_dma_o, hold_dma_o, ch_done_o, reg_wrh_o, reg_wrl_o, m_req, m_hold, m_done, m_wrh, m_wrl);
      else n_pass++;
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_write_decode();
    test_read_decode();
    test_dma_burst();
    test_grant_drop();
    test_arbitration();
    test_reset_mid_burst();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
